// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter for a shared UART transmitter. A granted requester keeps
// the transmitter locked across its burst until it marks a last byte or idles too long.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_valid,
  input  logic [7:0] cpu_data,
  input  logic       cpu_last,
  output logic       cpu_ready,
  input  logic       dbg_valid,
  input  logic [7:0] dbg_data,
  input  logic       dbg_last,
  output logic       dbg_ready,
  output logic       tx_wr,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       timeout_evt
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SEND      = 3'd1;
  localparam logic [2:0] S_WAIT_ACK  = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_HOLD      = 3'd4;

  localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        rr_q, rr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        tevt_q, tevt_d;

  logic        own_dbg;
  logic        own_valid;
  logic        own_last;
  logic [7:0]  own_data;
  logic        pick_dbg;

  assign own_dbg   = grant_q[1];
  assign own_valid = own_dbg ? dbg_valid : cpu_valid;
  assign own_last  = own_dbg ? dbg_last  : cpu_last;
  assign own_data  = own_dbg ? dbg_data  : cpu_data;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    tevt_d   = 1'b0;
    pick_dbg = 1'b0;
    case (state_q)
      S_IDLE: begin
        // rr_q = 1 names DBG; it only matters when both are requesting
        pick_dbg = (cpu_valid && dbg_valid) ? rr_q : dbg_valid;
        if (!tx_busy && (cpu_valid || dbg_valid)) begin
          grant_d = pick_dbg ? 2'b10 : 2'b01;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        last_d  = own_last;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (tx_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            grant_d = 2'b00;
            rr_d    = ~own_dbg;
            state_d = S_IDLE;
          end else begin
            cnt_d   = 16'd0;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // A byte arriving on the limit cycle still goes out; no revoke
        if (own_valid) begin
          state_d = S_SEND;
        end else if (cnt_q == CNT_LIMIT) begin
          grant_d = 2'b00;
          rr_d    = ~own_dbg;
          tevt_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      rr_q    <= 1'b0;
      cnt_q   <= 16'd0;
      last_q  <= 1'b0;
      tevt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      tevt_q  <= tevt_d;
    end
  end

  // Strobes decode straight from state so reset silences them at once
  assign tx_wr       = (state_q == S_SEND);
  assign tx_data     = tx_wr ? own_data : 8'h00;
  assign cpu_ready   = tx_wr & grant_q[0];
  assign dbg_ready   = tx_wr & grant_q[1];
  assign grant       = grant_q;
  assign timeout_evt = tevt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scenario bench for uart_tx_arbiter with a behavioural transmitter busy model
// and a byte-order scoreboard.
module tb_uart_tx_arbiter;

  localparam int FRAME = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cpu_valid = 1'b0;
  logic [7:0] cpu_data = 8'h00;
  logic       cpu_last = 1'b0;
  logic       cpu_ready;
  logic       dbg_valid = 1'b0;
  logic [7:0] dbg_data = 8'h00;
  logic       dbg_last = 1'b0;
  logic       dbg_ready;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       tx_busy = 1'b0;
  logic [1:0] grant;
  logic       timeout_evt;

  int n_chk = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_data(cpu_data), .cpu_last(cpu_last), .cpu_ready(cpu_ready),
    .dbg_valid(dbg_valid), .dbg_data(dbg_data), .dbg_last(dbg_last), .dbg_ready(dbg_ready),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant(grant), .timeout_evt(timeout_evt)
  );

  // Transmitter: busy from the edge after a write for FRAME cycles
  initial begin
    forever begin
      @(negedge clk);
      if (tx_wr && rst) begin
        wr_cnt++;
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (FRAME) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  task automatic wait_wr(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (tx_wr) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (grant == 2'b00 && !tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_busy_fall(output bit ok);
    bit seen;
    seen = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (tx_busy) begin
        seen = 1'b1;
        break;
      end
    end
    if (seen) begin
      for (int n = 0; n < 300; n++) begin
        @(negedge clk);
        if (!tx_busy) begin
          ok = 1'b1;
          break;
        end
      end
    end
  endtask

  // Drops the valid of whichever requester was just accepted
  task automatic retire_accepted();
    bit cr, dr;
    cr = cpu_ready;
    dr = dbg_ready;
    @(posedge clk);
    #1;
    if (cr) cpu_valid = 1'b0;
    if (dr) dbg_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++;
    if ({tx_wr, tx_data, cpu_ready, dbg_ready, timeout_evt} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 000", {tx_wr, tx_data, cpu_ready, dbg_ready, timeout_evt});
    end
    n_chk++;
    if (grant !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_grant: got %b want 00", grant);
    end
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_cpu_single();
    bit ok;
    int wr0;
    logic [7:0] exp;
    wr0 = wr_cnt;
    @(posedge clk);
    #1 cpu_valid = 1'b1; cpu_data = 8'h41; cpu_last = 1'b1;
    exp_q.push_back(8'h41);
    @(negedge clk);
    n_chk++;
    if (grant !== 2'b00) begin
      n_fail++;
      $display("FAIL single_grant_early: got %b want 00", grant);
    end
    @(negedge clk);
    n_chk++;
    if (grant !== 2'b01 || tx_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant_wr: got grant %b wr %b want 01 1", grant, tx_wr);
    end
    exp = exp_q.pop_front();
    n_chk++;
    if (tx_data !== exp || cpu_ready !== 1'b1 || dbg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_data: got %h rdy %b%b want %h rdy 10", tx_data, cpu_ready, dbg_ready, exp);
    end
    retire_accepted();
    wait_idle(ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_idle: got timeout want grant 00");
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (wr_cnt - wr0 !== 1) begin
      n_fail++;
      $display("FAIL single_wr_count: got %0d want 1", wr_cnt - wr0);
    end
  endtask

  task automatic test_tie(input logic [7:0] first, input logic [7:0] second, input logic [1:0] first_grant);
    bit ok;
    logic [7:0] exp;
    @(posedge clk);
    #1 cpu_valid = 1'b1; cpu_data = (first_grant == 2'b01) ? first : second; cpu_last = 1'b1;
    dbg_valid = 1'b1; dbg_data = (first_grant == 2'b01) ? second : first; dbg_last = 1'b1;
    exp_q.push_back(first);
    exp_q.push_back(second);
    for (int k = 0; k < 2; k++) begin
      wait_wr(ok);
      n_chk++;
      if (!ok) begin
        n_fail++;
        $display("FAIL tie_wr_%0d: got timeout want tx_wr", k);
      end else begin
        exp = exp_q.pop_front();
        n_chk++;
        if (tx_data !== exp) begin
          n_fail++;
          $display("FAIL tie_order_%0d: got %h want %h", k, tx_data, exp);
        end
        n_chk++;
        if (k == 0 && grant !== first_grant) begin
          n_fail++;
          $display("FAIL tie_grant: got %b want %b", grant, first_grant);
        end
        retire_accepted();
      end
    end
    wait_idle(ok);
  endtask

  task automatic test_dbg_burst();
    bit ok;
    logic [7:0] exp;
    @(posedge clk);
    #1 dbg_valid = 1'b1; dbg_data = 8'hA0; dbg_last = 1'b0;
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'h77);
    @(posedge clk);
    #1 cpu_valid = 1'b1; cpu_data = 8'h77; cpu_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_wr(ok);
      n_chk++;
      if (!ok) begin
        n_fail++;
        $display("FAIL burst_wr_%0d: got timeout want tx_wr", k);
        break;
      end
      exp = exp_q.pop_front();
      n_chk++;
      if (tx_data !== exp) begin
        n_fail++;
        $display("FAIL burst_order_%0d: got %h want %h", k, tx_data, exp);
      end
      if (k < 3) begin
        n_chk++;
        if (cpu_ready !== 1'b0 || dbg_ready !== 1'b1 || grant !== 2'b10) begin
          n_fail++;
          $display("FAIL burst_ready_%0d: got cpu %b dbg %b grant %b want 0 1 10", k, cpu_ready, dbg_ready, grant);
        end
      end
      @(posedge clk);
      #1;
      if (k == 0) dbg_data = 8'hA1;
      if (k == 1) begin dbg_data = 8'hA2; dbg_last = 1'b1; end
      if (k == 2) dbg_valid = 1'b0;
      if (k == 3) cpu_valid = 1'b0;
    end
    wait_idle(ok);
  endtask

  task automatic test_timeout();
    bit ok;
    int pulses;
    logic [7:0] exp;
    pulses = 0;
    @(posedge clk);
    #1 cpu_valid = 1'b1; cpu_data = 8'h55; cpu_last = 1'b0;
    exp_q.push_back(8'h55);
    wait_wr(ok);
    exp = exp_q.pop_front();
    n_chk++;
    if (!ok || tx_data !== exp) begin
      n_fail++;
      $display("FAIL to_first: got ok %b data %h want 1 %h", ok, tx_data, exp);
    end
    @(posedge clk);
    #1 cpu_valid = 1'b0;
    dbg_valid = 1'b1; dbg_data = 8'h66; dbg_last = 1'b1;
    exp_q.push_back(8'h66);
    wait_busy_fall(ok);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (timeout_evt) pulses++;
      if (n == 4) begin
        n_chk++;
        if (grant !== 2'b01 || dbg_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL to_hold: got grant %b dbg_ready %b want 01 0", grant, dbg_ready);
        end
      end
      if (n == 8) begin
        n_chk++;
        if (timeout_evt !== 1'b0) begin
          n_fail++;
          $display("FAIL to_early: got %b want 0", timeout_evt);
        end
      end
      if (n == 9) begin
        n_chk++;
        if (timeout_evt !== 1'b1 || grant !== 2'b00) begin
          n_fail++;
          $display("FAIL to_pulse: got evt %b grant %b want 1 00", timeout_evt, grant);
        end
      end
      if (n == 10) begin
        exp = exp_q.pop_front();
        n_chk++;
        if (tx_wr !== 1'b1 || grant !== 2'b10 || tx_data !== exp) begin
          n_fail++;
          $display("FAIL to_dbg_next: got wr %b grant %b data %h want 1 10 %h", tx_wr, grant, tx_data, exp);
        end
        @(posedge clk);
        #1 dbg_valid = 1'b0;
      end
    end
    n_chk++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL to_pulse_count: got %0d want 1", pulses);
    end
    wait_idle(ok);
  endtask

  task automatic test_valid_wins();
    bit ok;
    int pulses;
    logic [7:0] exp;
    pulses = 0;
    @(posedge clk);
    #1 cpu_valid = 1'b1; cpu_data = 8'h5A; cpu_last = 1'b0;
    exp_q.push_back(8'h5A);
    wait_wr(ok);
    exp = exp_q.pop_front();
    n_chk++;
    if (!ok || tx_data !== exp) begin
      n_fail++;
      $display("FAIL vw_first: got ok %b data %h want 1 %h", ok, tx_data, exp);
    end
    @(posedge clk);
    #1 cpu_valid = 1'b0;
    wait_busy_fall(ok);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (timeout_evt) pulses++;
      if (n == 7) begin
        @(posedge clk);
        #1 cpu_valid = 1'b1; cpu_data = 8'h5B; cpu_last = 1'b1;
        exp_q.push_back(8'h5B);
      end
      if (n == 9) begin
        exp = exp_q.pop_front();
        n_chk++;
        if (tx_wr !== 1'b1 || tx_data !== exp || grant !== 2'b01) begin
          n_fail++;
          $display("FAIL vw_send: got wr %b data %h grant %b want 1 %h 01", tx_wr, tx_data, grant, exp);
        end
        @(posedge clk);
        #1 cpu_valid = 1'b0;
      end
    end
    n_chk++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL vw_no_timeout: got %0d pulses want 0", pulses);
    end
    wait_idle(ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int wr1;
    logic [7:0] exp;
    // reset while the write strobe is up
    @(posedge clk);
    #1 cpu_valid = 1'b1; cpu_data = 8'hE1; cpu_last = 1'b1;
    wait_wr(ok);
    #1 rst = 1'b0;
    #1;
    n_chk++;
    if (tx_wr !== 1'b0 || cpu_ready !== 1'b0 || grant !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_send: got wr %b rdy %b grant %b want 0 0 00", tx_wr, cpu_ready, grant);
    end
    cpu_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    wait_idle(ok);
    // reset while waiting for the frame to finish
    @(posedge clk);
    #1 cpu_valid = 1'b1; cpu_data = 8'h99; cpu_last = 1'b1;
    exp_q.push_back(8'h99);
    wait_wr(ok);
    exp = exp_q.pop_front();
    n_chk++;
    if (!ok || tx_data !== exp) begin
      n_fail++;
      $display("FAIL rst_pre: got ok %b data %h want 1 %h", ok, tx_data, exp);
    end
    retire_accepted();
    for (int n = 0; n < 50 && !tx_busy; n++) @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_chk++;
    if ({tx_wr, tx_data, cpu_ready, dbg_ready, grant, timeout_evt} !== 14'h0000) begin
      n_fail++;
      $display("FAIL rst_wait_done: got %h want 0000", {tx_wr, tx_data, cpu_ready, dbg_ready, grant, timeout_evt});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    wait_idle(ok);
    wr1 = wr_cnt;
    @(posedge clk);
    #1 cpu_valid = 1'b1; cpu_data = 8'h3C; cpu_last = 1'b1;
    exp_q.push_back(8'h3C);
    wait_wr(ok);
    exp = exp_q.pop_front();
    n_chk++;
    if (!ok || tx_data !== exp) begin
      n_fail++;
      $display("FAIL rst_after: got ok %b data %h want 1 %h", ok, tx_data, exp);
    end
    retire_accepted();
    wait_idle(ok);
    repeat (4) @(negedge clk);
    n_chk++;
    if (wr_cnt - wr1 !== 1) begin
      n_fail++;
      $display("FAIL rst_wr_count: got %0d want 1", wr_cnt - wr1);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_cpu_single();
    test_tie(8'h32, 8'h31, 2'b10);
    apply_reset();
    test_tie(8'h11, 8'h22, 2'b01);
    test_dbg_burst();
    test_timeout();
    test_valid_wins();
    test_reset_mid();
    n_chk++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
